// File: rtl/cache_bank_core_rsp_queue_if.sv
// Handshake bundle between a cache bank pipeline, its response queue and the
// core response merge stage. The queue uses the slave view; the environment uses master.
interface cache_bank_core_rsp_queue_if #(
  parameter int NUM_REQS       = 4,
  parameter int WORD_SIZE      = 4,
  parameter int CORE_TAG_WIDTH = 8,
  parameter int CRSQ_SIZE      = 8
) ();
  localparam int REQS_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int WORD_WIDTH = 8 * WORD_SIZE;
  localparam int SIZE_W     = $clog2(CRSQ_SIZE) + 1;

  logic                      push_valid;
  logic [CORE_TAG_WIDTH-1:0] push_tag;
  logic [REQS_BITS-1:0]      push_tid;
  logic [WORD_WIDTH-1:0]     push_data;
  logic                      push_ready;
  logic                      almost_full;
  logic [SIZE_W-1:0]         size;

  logic                      core_rsp_valid;
  logic [CORE_TAG_WIDTH-1:0] core_rsp_tag;
  logic [REQS_BITS-1:0]      core_rsp_tid;
  logic [WORD_WIDTH-1:0]     core_rsp_data;
  logic                      core_rsp_ready;

  modport slave (
    input  push_valid, push_tag, push_tid, push_data, core_rsp_ready,
    output push_ready, almost_full, size,
    output core_rsp_valid, core_rsp_tag, core_rsp_tid, core_rsp_data
  );

  modport master (
    output push_valid, push_tag, push_tid, push_data, core_rsp_ready,
    input  push_ready, almost_full, size,
    input  core_rsp_valid, core_rsp_tag, core_rsp_tid, core_rsp_data
  );
endinterface

// File: rtl/cache_bank_core_rsp_queue.sv
// Per-bank FIFO of core responses {tag, tid, data}. The head entry is held in a
// prefetched output register so core_rsp_* come straight from flops.
module cache_bank_core_rsp_queue #(
  parameter int NUM_REQS        = 4,
  parameter int WORD_SIZE       = 4,
  parameter int CORE_TAG_WIDTH  = 8,
  parameter int CRSQ_SIZE       = 8,
  parameter int ALM_FULL_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  cache_bank_core_rsp_queue_if.slave    bus
);
  localparam int REQS_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int WORD_WIDTH = 8 * WORD_SIZE;
  localparam int PTR_W      = $clog2(CRSQ_SIZE);
  localparam int SIZE_W     = PTR_W + 1;

  typedef struct packed {
    logic [CORE_TAG_WIDTH-1:0] tag;
    logic [REQS_BITS-1:0]      tid;
    logic [WORD_WIDTH-1:0]     data;
  } entry_t;

  entry_t            r_mem [CRSQ_SIZE];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [SIZE_W-1:0] r_size;
  logic              r_push_ready;
  logic              r_almost_full;
  logic              r_head_valid;
  entry_t            r_head;

  logic              w_push_acc;
  logic              w_pop_acc;
  entry_t            w_push_entry;
  logic [SIZE_W-1:0] w_size_next;
  logic [SIZE_W-1:0] w_remain;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic              w_head_valid_next;
  entry_t            w_head_next;

  assign w_push_acc    = bus.push_valid & r_push_ready;
  assign w_pop_acc     = r_head_valid & bus.core_rsp_ready;
  assign w_push_entry  = {bus.push_tag, bus.push_tid, bus.push_data};
  assign w_size_next   = r_size + SIZE_W'(w_push_acc) - SIZE_W'(w_pop_acc);
  assign w_remain      = r_size - SIZE_W'(w_pop_acc);
  assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop_acc);

  // Head prefetch: the next oldest stored entry if one survives this cycle,
  // otherwise the entry being pushed right now (lands after this edge, no bypass).
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_head_valid_next = 1'b0;
    w_head_next       = r_head;
    if (w_remain != '0) begin
      w_head_valid_next = 1'b1;
      w_head_next       = r_mem[w_rd_ptr_next];
    end else if (w_push_acc) begin
      w_head_valid_next = 1'b1;
      w_head_next       = w_push_entry;
    end
  end

  // NOTE: the storage array is deliberately left without reset; occupancy and
  // pointers decide which slots are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_size        <= '0;
      r_push_ready  <= 1'b1;
      r_almost_full <= 1'b0;
      r_head_valid  <= 1'b0;
      r_head        <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr      <= w_rd_ptr_next;
      r_size        <= w_size_next;
      r_push_ready  <= (w_size_next < SIZE_W'(CRSQ_SIZE));
      r_almost_full <= (w_size_next >= SIZE_W'(CRSQ_SIZE - ALM_FULL_MARGIN));
      r_head_valid  <= w_head_valid_next;
      r_head        <= w_head_next;
    end
  end

  assign bus.push_ready     = r_push_ready;
  assign bus.almost_full    = r_almost_full;
  assign bus.size           = r_size;
  assign bus.core_rsp_valid = r_head_valid;
  assign bus.core_rsp_tag   = r_head.tag;
  assign bus.core_rsp_tid   = r_head.tid;
  assign bus.core_rsp_data  = r_head.data;

  a_tid_range: assert property (@(posedge clk) disable iff (!reset)
    bus.push_valid |-> ({1'b0, bus.push_tid} < (REQS_BITS + 1)'(NUM_REQS)));

  a_size_bound: assert property (@(posedge clk) disable iff (!reset)
    r_size <= SIZE_W'(CRSQ_SIZE));
endmodule
